// File: rtl/sub_bytes_seq.sv
// Time-multiplexed SubBytes/InvSubBytes engine for the 128-bit AES state.
// LANES byte cells are reused over 16/LANES passes behind a valid/ready handshake.

package sub_bytes_pkg;
  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction
endpackage

// Forward S-box cell: one registered lookup, 1 clk latency.
module sbox (
  input  logic       clk,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  import sub_bytes_pkg::*;
  logic [7:0] out_d, out_q;

  // Substitution value for the presented byte.
  always_comb out_d = fwd_affine(gf_inv(in_byte));

  // Result register; pure datapath, so it carries no reset.
  // NOTE: data-only registers are left unreset; only control state needs a known value.
  always_ff @(posedge clk) out_q <= out_d;

  assign out_byte = out_q;
endmodule

// Inverse S-box cell: same interface and timing as sbox.
module inv_sbox (
  input  logic       clk,
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  import sub_bytes_pkg::*;
  logic [7:0] out_d, out_q;

  // Inverse substitution value for the presented byte.
  always_comb out_d = gf_inv(inv_affine(in_byte));

  // Result register.
  always_ff @(posedge clk) out_q <= out_d;

  assign out_byte = out_q;
endmodule

module sub_bytes_seq #(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  localparam int P  = 16 / LANES;
  localparam int GW = LANES * 8;
  localparam int CW = $clog2(P + 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   issue_q, issue_d;
  logic [127:0]    src_q, src_d;
  logic            mode_q, mode_d;
  logic [127:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [GW-1:0]   lane_in, lane_out;
  logic [7:0]      fwd_out [LANES];
  logic [7:0]      inv_out [LANES];
  logic            accept;

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == RUN) || (state_q == DONE);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    sbox u_fwd (.clk(clk), .in_byte(lane_in[j*8 +: 8]), .out_byte(fwd_out[j]));
    if (INV_EN != 0) begin : g_inv
      inv_sbox u_inv (.clk(clk), .in_byte(lane_in[j*8 +: 8]), .out_byte(inv_out[j]));
    end else begin : g_no_inv
      assign inv_out[j] = '0;
    end
  end

  // Route the issuing group to the lanes and pick forward/inverse results.
  always_comb begin
    lane_in = '0;
    for (int g = 0; g < P; g++) begin
      if (issue_q == CW'(g)) lane_in = src_q[g*GW +: GW];
    end
    for (int j = 0; j < LANES; j++) begin
      lane_out[j*8 +: 8] = mode_q ? inv_out[j] : fwd_out[j];
    end
  end

  // Next-state, writeback and accept logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    issue_d     = issue_q;
    src_d       = src_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      RUN: begin
        // Writeback lags issue by one cycle: count c writes group c-1.
        for (int g = 0; g < P; g++) begin
          if (issue_q == CW'(g + 1)) out_data_d[g*GW +: GW] = lane_out;
        end
        if (issue_q == CW'(P)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          issue_d = issue_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      src_d   = in_data;
      mode_d  = (INV_EN != 0) ? in_inv : 1'b0;
      issue_d = '0;
      state_d = RUN;
    end
  end

  // Control and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= IDLE;
      issue_q     <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_q     <= issue_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Source register; only read after an accept has loaded it.
  always_ff @(posedge clk) src_q <= src_d;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: several configurations run side by side,
// each against a transaction-level model built on a table-generated S-box.
module tb_sub_bytes_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] subst(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? isbox_t[s[8*i +: 8]] : sbox_t[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] vec_data(input int i);
    case (i)
      0: return 128'h0f0e0d0c0b0a09080706050403020100;
      1: return 128'h76abd7fe2b670130c56f6bf27b777c63;
      2: return '0;
      3: return '1;
      default: return '0;
    endcase
  endfunction

  function automatic logic vec_inv(input int i);
    return (i == 1 || i == 2);
  endfunction

  // Build the S-box with the generator walk over GF(2^8) and invert it.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  for (genvar gi = 0; gi < 6; gi++) begin : g_cfg
    localparam int L  = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 8 : (gi == 4) ? 16 : 4;
    localparam int IE = (gi == 5) ? 0 : 1;
    localparam int P  = 16 / L;

    logic         in_valid = 1'b0;
    logic         in_inv   = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data  = '0;
    logic         in_ready, out_valid, busy;
    logic [127:0] out_data;

    bit           m_has    = 1'b0;
    int           m_cnt    = 0;
    logic [127:0] m_res    = '0;
    bit           accepted = 1'b0;
    int           vec_idx  = 0;

    sub_bytes_seq #(.LANES(L), .INV_EN(IE)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    // Compare against the model, then advance the model to the coming edge.
    always @(negedge clk) begin
      logic exp_ready, exp_valid, acc;
      string tag;
      tag       = $sformatf("L%0d_inv%0d", L, IE);
      exp_ready = !rst && (!m_has || (m_cnt == 0 && out_ready));
      exp_valid = m_has && (m_cnt == 0);
      check({tag, "_in_ready"}, 128'(in_ready), 128'(exp_ready));
      check({tag, "_out_valid"}, 128'(out_valid), 128'(exp_valid));
      check({tag, "_busy"}, 128'(busy), 128'(m_has));
      if (exp_valid) check({tag, "_out_data"}, out_data, m_res);
      accepted = 1'b0;
      if (rst) begin
        m_has = 1'b0;
      end else begin
        acc = in_valid && exp_ready;
        if (m_has && m_cnt == 0 && out_ready) m_has = 1'b0;
        else if (m_has && m_cnt > 0) m_cnt--;
        if (acc) begin
          m_has = 1'b1;
          m_cnt = P + 1;
          m_res = subst(in_data, (IE != 0) ? in_inv : 1'b0);
        end
        accepted = acc;
      end
    end

    // Upstream holds a block until accepted; downstream stalls in periodic windows.
    always @(posedge clk) begin
      #1;
      if (!in_valid || accepted) begin
        if (vec_idx < 5) begin
          in_valid = 1'b1;
          in_data  = vec_data(vec_idx);
          in_inv   = vec_inv(vec_idx);
          vec_idx++;
        end else begin
          in_valid = ($urandom_range(3) != 0);
          in_data  = {$urandom, $urandom, $urandom, $urandom};
          in_inv   = 1'($urandom_range(1));
        end
      end
      out_ready = ((cyc % 97) < 12) ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  initial begin
    build_tables();
    check("tbl_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
    check("tbl_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
    check("tbl_sbox_ff", 128'(sbox_t[8'hff]), 128'h16);
    check("tbl_isbox_63", 128'(isbox_t[8'h63]), 128'h00);
    check("model_fwd_vec", subst(128'h0f0e0d0c0b0a09080706050403020100, 1'b0),
          128'h76abd7fe2b670130c56f6bf27b777c63);
    check("model_inv_vec", subst(128'h76abd7fe2b670130c56f6bf27b777c63, 1'b1),
          128'h0f0e0d0c0b0a09080706050403020100);
    check("model_inv_zero", subst('0, 1'b1), {16{8'h52}});
    check("model_fwd_zero", subst('0, 1'b0), {16{8'h63}});
    check("model_fwd_ones", subst('1, 1'b0), {16{8'h16}});
    repeat (3000) begin
      @(posedge clk);
      #1;
      rst = (cyc < 2) || ($urandom_range(149) == 0);
      cyc++;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Parametrised, handshaked SubBytes/InvSubBytes engine for the 128-bit AES state. It time-multiplexes LANES byte-substitution cells over the 16 state bytes, so one design can trade area for latency. It sits between the round controller and shift_rows/inv_shift_rows, and replaces the fixed 16-cell, free-running substitution stage with a valid/ready stage that supports per-block direction selection.

Parameters:
LANES, 4, number of parallel byte-substitution cells; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
INV_EN, 1, 1 = inverse S-box lanes are instantiated and in_inv is honoured; 0 = forward only, in_inv is ignored.

Ports:
clk  input  1  system clock; all logic is rising-edge.
rst  input  1  reset, synchronous, active-high.
in_valid  input  1  in_data and in_inv are valid.
in_ready  output  1  block can accept a new state.
in_data  input  128  state; byte i = bits [8i+7:8i].
in_inv  input  1  1 = InvSubBytes, 0 = SubBytes; sampled on accept.
out_valid  output  1  out_data holds a completed result.
out_ready  input  1  downstream accepts out_data.
out_data  output  128  substituted state, same byte order as in_data.
busy  output  1  high in RUN or DONE.

Behaviour:
- P = 16/LANES passes. Each lane is a registered lookup with 1 clk latency: the forward cell is sbox; the inverse cell is inv_sbox, a new cell with the same interface and timing, delivered with this block.
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Reset values: out_valid=0, out_data=0, busy=0, pass counter=0, captured mode=0. in_ready=0 while rst is high.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and is forced to 0 during rst.
- Accept occurs on a rising edge with in_valid & in_ready. On accept:
  - in_data is latched into the source register and in_inv into the mode register (the mode register is forced to 0 when INV_EN=0).
  - The issue counter is cleared and the FSM moves to RUN.
- RUN, issue side: in the cycle with issue count k (0..P-1), source bytes k*LANES+j (j=0..LANES-1) drive lane j. The mode register selects the forward or inverse lane output.
- RUN, writeback side: lags issue by one cycle. The writeback of group k writes result bytes k*LANES+j.
- After the writeback of group P-1, the FSM moves to DONE and out_valid=1.
- Latency: out_valid rises exactly P+1 clocks after the accept edge. Examples: LANES=16 gives 2, LANES=4 gives 5, LANES=1 gives 17.
- DONE: out_data and out_valid are held stable until out_valid & out_ready.
  - Handshake with no new accept: the FSM returns to IDLE and out_valid drops on the same edge.
  - Handshake with a simultaneous accept: the new block is captured, the FSM goes directly to RUN, and out_valid drops. This back-to-back throughput is one block per P+1 cycles.
- out_data is registered. Its contents update only on writeback and are meaningful only while out_valid=1.
- in_valid during RUN is ignored, because in_ready=0. The input is not latched and the upstream must hold it.
- in_inv changing after accept has no effect on the block in flight.
- rst asserted mid-operation aborts the block on that edge: the FSM goes to IDLE, out_valid=0, and no partial result is ever presented.
- A 1-cycle rst pulse during DONE with out_ready=0 discards the result.
- Result bytes not yet written are undefined but invisible, because out_valid=0.

Test Plan:
- LANES=4, SubBytes: in_data=128'h0f0e0d0c0b0a09080706050403020100, in_inv=0 -> out_valid rises 5 clks after accept; out_data=128'h76abd7fe2b670130c56f6bf27b777c63.
- LANES=4, InvSubBytes: feed 128'h76abd7fe2b670130c56f6bf27b777c63 with in_inv=1 -> out_data=128'h0f0e0d0c0b0a09080706050403020100. Then all-zero input with in_inv=1 -> 128'h5252...52.
- Sweep LANES over 1, 2, 8 and 16 with input 128'h00...00 and in_inv=0 -> out_data=128'h6363...63 at latencies 17, 9, 3 and 2 respectively. Input 128'hff...ff -> 128'h1616...16.
- Backpressure: hold out_ready=0 for 10 clks in DONE -> out_data and out_valid stay stable and in_ready=0. Then raise out_ready together with in_valid -> the new block is accepted on the same edge and out_valid drops for exactly P+1 clks.
- Mid-operation reset: pulse rst for 1 clk at issue count 2 -> next cycle state IDLE, out_valid=0, in_ready=1. A following block produces a correct result with no residue from the aborted one.
- INV_EN=0: in_inv=1 with input 128'h00...00 -> out_data=128'h6363...63, i.e. the forward table is used.
